// File: rtl/hi_simulate_multimode.sv
// HF tag-emulator front end: ADC hysteresis comparator streamed to the ARM over SSP, and
// antenna load modulation from an ARM bitstream in BPSK / 212k / 424k / Manchester subcarrier modes.
module hi_simulate_multimode #(
  parameter int ADC_W      = 8,
  parameter int DIV_W      = 9,
  parameter int FRAME_BITS = 8,
  parameter int HYST_HI    = 224,
  parameter int HYST_LO    = 31
) (
  input  logic             ck_1356meg,
  input  logic             rst,
  input  logic [ADC_W-1:0] adc_d,
  output logic             adc_clk,
  input  logic [2:0]       mod_type,
  input  logic             ssp_dout,
  output logic             ssp_clk,
  output logic             ssp_frame,
  output logic             ssp_din,
  output logic             pwr_hi,
  output logic             pwr_lo,
  output logic             pwr_oe1,
  output logic             pwr_oe2,
  output logic             pwr_oe3,
  output logic             pwr_oe4,
  output logic             dbg
);

  localparam logic [2:0] MODE_NO_MOD     = 3'd0;
  localparam logic [2:0] MODE_BPSK       = 3'd1;
  localparam logic [2:0] MODE_212K       = 3'd2;
  localparam logic [2:0] MODE_MANCHESTER = 3'd3;
  localparam logic [2:0] MODE_424K       = 3'd4;
  localparam logic [2:0] MODE_424K_8BIT  = 3'd5;

  localparam logic [ADC_W-1:0] THR_HI   = ADC_W'(HYST_HI);
  localparam logic [ADC_W-1:0] THR_LO   = ADC_W'(HYST_LO);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

  logic [DIV_W-1:0] div;
  logic [3:0]       bitcnt;
  logic [2:0]       mode_q;
  logic [3:0]       k;
  logic             hyst;
  logic             tx_bit;
  logic             mod_out;
  logic             mod_next;
  logic             strobe;
  logic             mode_chg;

  // Bit period is 2^(k+1) carrier clocks.
  always_comb begin
    k = 4'd4;
    case (mode_q)
      MODE_212K:       k = 4'd5;
      MODE_424K_8BIT:  k = 4'd7;
      MODE_MANCHESTER: k = 4'd6;
      default:         k = 4'd4;
    endcase
  end

  // Bit boundary: the cycle in which ssp_clk is about to rise.
  assign strobe   = ~ssp_clk & ~div[k];
  assign mode_chg = (mod_type != mode_q);

  always_comb begin
    mod_next = 1'b0;
    case (mode_q)
      MODE_NO_MOD:               mod_next = 1'b0;
      MODE_BPSK:                 mod_next = tx_bit ^ div[3];
      MODE_212K:                 mod_next = tx_bit & div[5];
      MODE_424K, MODE_424K_8BIT: mod_next = tx_bit & div[4];
      // Logic 1 carries the 847 kHz burst in the first half-bit, logic 0 in the second.
      MODE_MANCHESTER:           mod_next = div[3] & (tx_bit ? ~div[6] : div[6]);
      default:                   mod_next = 1'b0;
    endcase
  end

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      div       <= '0;
      bitcnt    <= '0;
      hyst      <= 1'b0;
      tx_bit    <= 1'b0;
      ssp_clk   <= 1'b0;
      ssp_frame <= 1'b0;
      ssp_din   <= 1'b0;
      mod_out   <= 1'b0;
      // Absorb the mode now so releasing reset does not look like a mode change.
      mode_q    <= mod_type;
    end else begin
      mode_q <= mod_type;

      if (adc_d >= THR_HI)
        hyst <= 1'b1;
      else if (adc_d <= THR_LO)
        hyst <= 1'b0;

      if (mode_chg) begin
        div       <= '0;
        bitcnt    <= '0;
        ssp_clk   <= 1'b0;
        tx_bit    <= 1'b0;
        ssp_frame <= 1'b0;
        mod_out   <= 1'b0;
      end else begin
        div     <= div + DIV_W'(1);
        ssp_clk <= ~div[k];
        mod_out <= mod_next;
        if (strobe) begin
          ssp_din   <= hyst;
          tx_bit    <= ssp_dout;
          bitcnt    <= (bitcnt == LAST_BIT) ? 4'd0 : bitcnt + 4'd1;
          ssp_frame <= (bitcnt == LAST_BIT);
        end
      end
    end
  end

  assign adc_clk = ck_1356meg;
  assign pwr_oe1 = mod_out;
  assign pwr_oe4 = mod_out;
  assign pwr_hi  = 1'b0;
  assign pwr_lo  = 1'b0;
  assign pwr_oe2 = 1'b0;
  assign pwr_oe3 = 1'b0;
  assign dbg     = ssp_frame;

endmodule
